fa_resp_checker: RTL and testbench

FA_RESP_CHECKER -- requirements
Module: fa_resp_checker

---
 rtl/fa_chk_pkg.sv | 15 +
 rtl/fa_golden.sv | 13 +
 rtl/fa_resp_checker.sv | 134 +++++++++++++
 tb/tb_fa_resp_checker.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fa_chk_pkg.sv
// Shared types and constants for the full-adder response checker.
package fa_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam int unsigned N_VECS = 8;
  localparam int unsigned VEC_W  = 3;
  localparam int unsigned ERR_W  = 4;

endpackage

// File: rtl/fa_golden.sv
// Reference full adder: the response a correct device must return.
module fa_golden (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/fa_resp_checker.sv
// Drives all eight {a,b,cin} vectors into an external full adder, waits SETTLE
// cycles per vector, then compares its sum/cout against the golden model.
module fa_resp_checker
  import fa_chk_pkg::*;
#(
  parameter int SETTLE   = 2,
  parameter int NUM_VECS = N_VECS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_cin,
  input  logic             dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [VEC_W-1:0] fail_vec
);

  localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(NUM_VECS - 1);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   idx_q, idx_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               fail_valid_q, fail_valid_d;
  logic [VEC_W-1:0]   fail_vec_q, fail_vec_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               busy_q, busy_d;
  logic [VEC_W-1:0]   stim_q, stim_d;

  logic exp_sum, exp_cout, mismatch;

  fa_golden u_golden (
    .a    (idx_q[2]),
    .b    (idx_q[1]),
    .cin  (idx_q[0]),
    .sum  (exp_sum),
    .cout (exp_cout)
  );

  assign mismatch = (dut_sum != exp_sum) || (dut_cout != exp_cout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      busy_q       <= 1'b0;
      stim_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      busy_q       <= busy_d;
      stim_q       <= stim_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_SETTLE;
      ST_SETTLE:        if (cnt_q == SETTLE_LAST) state_d = ST_CHECK;
      ST_CHECK:         state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_SETTLE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from next-state values so every port comes straight from a flop.
  always_comb begin
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    done_d       = done_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          idx_d        = '0;
          cnt_d        = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          done_d       = 1'b0;
        end
      end
      ST_SETTLE: cnt_d = cnt_q + 4'd1;
      ST_CHECK: begin
        cnt_d = '0;
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = idx_q;
          end
        end
        if (idx_q == LAST_IDX) done_d = 1'b1;
        else                   idx_d  = idx_q + 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    stim_d = busy_d ? idx_d : '0;
    pass_d = done_d && (err_d == '0);
  end

  assign {dut_a, dut_b, dut_cin} = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_fa_resp_checker.sv
// Bench for fa_resp_checker: two instances (SETTLE=2 and SETTLE=1) share start/reset.
module tb_fa_resp_checker;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pass;
    logic       fv;
    logic [2:0] fvec;
    logic [3:0] err;
    logic [2:0] stim;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   fault_mode = 0;   // 0 correct adder, 1 cout stuck at 0, 2 sum inverted
  int   checks = 0;
  int   failures = 0;

  obs_t obs   [2];
  obs_t exp_o [2];

  always #5 clk = ~clk;

  // Response of the adder stand-in for vector v, judged against arithmetic a+b+cin.
  function automatic bit resp_bad(input int v, input int mode);
    int s, gs, gc, rs, rc;
    s  = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
    gs = s % 2;
    gc = s / 2;
    rs = (mode == 2) ? 1 - gs : gs;
    rc = (mode == 1) ? 0 : gc;
    return (rs != gs) || (rc != gc);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, req, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_u
    localparam int S = (gi == 0) ? 2 : 1;
    logic       a, b, cin, sum, cout, busy, done, pass, fv;
    logic [3:0] err;
    logic [2:0] fvec;
    logic [2:0] stim_exp;
    int k = 0;
    bit mdone = 0;
    int merr = 0;
    bit mfv = 0;
    int mfvec = 0;

    fa_resp_checker #(.SETTLE(S), .NUM_VECS(8)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .dut_a      (a),
      .dut_b      (b),
      .dut_cin    (cin),
      .dut_sum    (sum),
      .dut_cout   (cout),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_count  (err),
      .fail_valid (fv),
      .fail_vec   (fvec)
    );

    assign sum  = (fault_mode == 2) ? ~(a ^ b ^ cin) : (a ^ b ^ cin);
    assign cout = (fault_mode == 1) ? 1'b0 : ((a & b) | (a & cin) | (b & cin));

    assign obs[gi] = {busy, done, pass, fv, fvec, err, a, b, cin};

    // k counts cycles into a run (0 = not running); every (S+1)th cycle is a check.
    assign stim_exp  = (k > 0) ? 3'((k - 1) / (S + 1)) : 3'd0;
    assign exp_o[gi] = {(k > 0), mdone, (mdone && merr == 0), mfv, mfvec[2:0], merr[3:0], stim_exp};

    initial begin
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          k = 0; mdone = 0; merr = 0; mfv = 0; mfvec = 0;
        end else if (k == 0) begin
          if (start) begin
            k = 1; mdone = 0; merr = 0; mfv = 0; mfvec = 0;
          end
        end else begin
          if ((k - 1) % (S + 1) == S) begin
            if (resp_bad((k - 1) / (S + 1), fault_mode)) begin
              merr++;
              if (!mfv) begin
                mfv = 1;
                mfvec = (k - 1) / (S + 1);
              end
            end
          end
          if (k == 8 * (S + 1)) begin
            k = 0;
            mdone = 1;
          end else begin
            k++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d busy", i), 32'(obs[i].busy), 32'(exp_o[i].busy));
      chk($sformatf("u%0d done", i), 32'(obs[i].done), 32'(exp_o[i].done));
      chk($sformatf("u%0d pass", i), 32'(obs[i].pass), 32'(exp_o[i].pass));
      chk($sformatf("u%0d fail_valid", i), 32'(obs[i].fv), 32'(exp_o[i].fv));
      chk($sformatf("u%0d fail_vec", i), 32'(obs[i].fvec), 32'(exp_o[i].fvec));
      chk($sformatf("u%0d err_count", i), 32'(obs[i].err), 32'(exp_o[i].err));
      chk($sformatf("u%0d stimulus", i), 32'(obs[i].stim), 32'(exp_o[i].stim));
    end
  end

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s u%0d outputs", tag, i), 32'(obs[i]), 32'd0);
    end
  endtask

  task automatic run_timed(input bit repulse, output int t0, output int t1,
                           output int b0, output int b1);
    t0 = 0; t1 = 0; b0 = 0; b1 = 0;
    #2 start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 60; n++) begin
      #1;
      if (n == 0) begin
        chk("restart clears err u0", 32'(obs[0].err), 32'd0);
        chk("restart clears done u0", 32'(obs[0].done), 32'd0);
        chk("restart clears fail_valid u1", 32'(obs[1].fv), 32'd0);
      end
      if (obs[0].busy) b0++;
      if (obs[1].busy) b1++;
      if (t0 == 0 && obs[0].done) t0 = n + 1;
      if (t1 == 0 && obs[1].done) t1 = n + 1;
      #1 start = repulse && (n == 4 || n == 11);
      @(posedge clk);
    end
  endtask

  task automatic run_and_report(input string tag, input bit repulse,
                                input int req_err, input int req_fvec);
    int t0, t1, b0, b1;
    run_timed(repulse, t0, t1, b0, b1);
    $display("run %s: done_latency=%0d/%0d busy=%0d/%0d err=%0d/%0d", tag, t0, t1, b0, b1,
             obs[0].err, obs[1].err);
    chk({tag, " latency u0"}, 32'(t0), 32'd25);
    chk({tag, " latency u1"}, 32'(t1), 32'd17);
    chk({tag, " busy cycles u0"}, 32'(b0), 32'd24);
    chk({tag, " busy cycles u1"}, 32'(b1), 32'd16);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s u%0d err_count", tag, i), 32'(obs[i].err), 32'(req_err));
      chk($sformatf("%s u%0d fail_valid", tag, i), 32'(obs[i].fv), 32'(req_err != 0));
      chk($sformatf("%s u%0d fail_vec", tag, i), 32'(obs[i].fvec), 32'(req_fvec));
      chk($sformatf("%s u%0d pass", tag, i), 32'(obs[i].pass), 32'(req_err == 0));
    end
  endtask

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    #1 chk_zero("in reset");
    #1 rst_n = 1'b1;

    fault_mode = 0;
    run_and_report("correct", 1'b0, 0, 0);
    fault_mode = 1;
    run_and_report("cout_stuck0", 1'b0, 4, 3);
    fault_mode = 2;
    run_and_report("sum_inverted", 1'b0, 8, 0);
    fault_mode = 0;
    run_and_report("repulse", 1'b1, 0, 0);

    // Abort a faulty run at index 4, after one mismatch has been recorded.
    fault_mode = 1;
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(posedge clk);
      #1 if (obs[0].stim == 3'd4) found = 1'b1;
    end
    chk("reached index 4", 32'(found), 32'd1);
    chk("err before reset", 32'(obs[0].err), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_zero("async reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1 chk_zero("idle after reset");
    $display("reset mid-run: outputs cleared, idle for 30 cycles");
    fault_mode = 0;
    run_and_report("after_reset", 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
